// File: rtl/lcd_rgb_rx.sv
// LCD RGB parallel-interface receiver: captures DE-qualified pixels, tracks x/y
// position and measures line/frame timing to report a stable (locked) video mode.
module lcd_rgb_rx #(
    parameter int HS_ACT_HIGH = 0,
    parameter int VS_ACT_HIGH = 0,
    parameter int CNT_W       = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             lcd_de,
    input  logic             lcd_hs,
    input  logic             lcd_vs,
    input  logic [23:0]      lcd_rgb,
    output logic             pix_valid,
    output logic [23:0]      pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] v_total,
    output logic             locked,
    output logic             line_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t state, state_nxt;

    logic        hs_in, vs_in;
    logic        s1_de, s2_de, s1_hs, s2_hs, s1_vs, s2_vs;
    logic [23:0] s1_rgb, s2_rgb;

    logic [CNT_W-1:0] hcnt;        // cycles since last hs edge
    logic [CNT_W-1:0] de_cnt;      // s2 DE-high cycles in current line
    logic [CNT_W-1:0] ln_cnt;      // DE lines in current frame
    logic [CNT_W-1:0] hl_cnt;      // hs edges in current frame
    logic [CNT_W-1:0] first_len;
    logic             first_seen;
    logic             hs_seen;
    logic [CNT_W-1:0] prev_ha, prev_ht, prev_va, prev_vt;
    logic             prev_ok;

    // Syncs are folded to active-high before the synchroniser, so a cleared
    // register always means "sync deasserted" regardless of panel polarity.
    assign hs_in = (HS_ACT_HIGH != 0) ? lcd_hs : ~lcd_hs;
    assign vs_in = (VS_ACT_HIGH != 0) ? lcd_vs : ~lcd_vs;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would turn the s1->s2 pipe into one stage.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_de  <= 1'b0;
            s2_de  <= 1'b0;
            s1_hs  <= 1'b0;
            s2_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s2_vs  <= 1'b0;
            s1_rgb <= '0;
            s2_rgb <= '0;
        end else begin
            s1_de  <= lcd_de;
            s2_de  <= s1_de;
            s1_hs  <= hs_in;
            s2_hs  <= s1_hs;
            s1_vs  <= vs_in;
            s2_vs  <= s1_vs;
            s1_rgb <= lcd_rgb;
            s2_rgb <= s1_rgb;
        end
    end

    logic vs_rise, vs_fall, hs_rise, de_rise, de_fall;
    logic in_frame, timeout, line_end, frame_start, frame_end, len_bad;
    logic [CNT_W-1:0] line_len, ha_fin, ht_fin, va_fin, vt_fin;
    logic             err_fin, meas_same;

    assign vs_rise = s1_vs & ~s2_vs;
    assign vs_fall = ~s1_vs & s2_vs;
    assign hs_rise = s1_hs & ~s2_hs;
    assign de_rise = s1_de & ~s2_de;
    assign de_fall = ~s1_de & s2_de;

    assign in_frame    = (state == FRAME);
    assign timeout     = (hcnt == CNT_MAX) && !hs_rise;
    assign line_end    = de_fall && in_frame;
    assign frame_start = (state == SYNC) && vs_fall && !timeout;
    assign frame_end   = vs_rise && in_frame && !timeout;

    // The DE-fall cycle itself is the last s2-high cycle of the line.
    assign line_len = sat_inc(de_cnt);
    assign len_bad  = line_end && first_seen && (line_len != first_len);

    // Values of the just-finished frame, folding in any same-cycle line end
    // or hs edge so a coincident vs edge never loses the last line.
    assign ha_fin  = line_end ? line_len : h_active;
    assign ht_fin  = (hs_rise && hs_seen) ? hcnt : h_total;
    assign va_fin  = line_end ? sat_inc(ln_cnt) : ln_cnt;
    assign vt_fin  = hl_cnt;
    assign err_fin = line_err | len_bad;
    assign meas_same = (ha_fin == prev_ha) && (ht_fin == prev_ht) &&
                       (va_fin == prev_va) && (vt_fin == prev_vt);

    assign pix_valid = s2_de && in_frame && !s2_vs;
    assign pix_data  = s2_rgb;
    assign pix_sof   = pix_valid && (pix_x == '0) && (pix_y == '0);
    assign pix_eol   = pix_valid && !s1_de;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // NOTE: next-state starts from a default so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = SYNC;
            SYNC:    if (vs_fall) state_nxt = FRAME;
            FRAME:   if (vs_rise) state_nxt = SYNC;
            default: state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    // NOTE: every register, including the stored reference measurements, is
    // cleared by reset so a mid-frame reset leaves no stale timing behind.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hcnt       <= '0;
            hs_seen    <= 1'b0;
            h_total    <= '0;
            de_cnt     <= '0;
            h_active   <= '0;
            first_len  <= '0;
            first_seen <= 1'b0;
            line_err   <= 1'b0;
            ln_cnt     <= '0;
            hl_cnt     <= '0;
            v_active   <= '0;
            v_total    <= '0;
            prev_ha    <= '0;
            prev_ht    <= '0;
            prev_va    <= '0;
            prev_vt    <= '0;
            prev_ok    <= 1'b0;
            locked     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
        end else begin
            hcnt <= hs_rise ? CNT_ONE : sat_inc(hcnt);

            // After a timeout the next hs edge only restarts the period count.
            if (timeout)      hs_seen <= 1'b0;
            else if (hs_rise) hs_seen <= 1'b1;

            if (hs_rise && hs_seen) h_total <= hcnt;

            if (de_rise)    de_cnt <= '0;
            else if (s2_de) de_cnt <= sat_inc(de_cnt);

            if (line_end) h_active <= line_len;

            if (frame_start) begin
                line_err   <= 1'b0;
                first_seen <= 1'b0;
            end else if (line_end) begin
                if (!first_seen) begin
                    first_len  <= line_len;
                    first_seen <= 1'b1;
                end else if (len_bad) begin
                    line_err <= 1'b1;
                end
            end

            if (vs_rise)       ln_cnt <= '0;
            else if (line_end) ln_cnt <= sat_inc(ln_cnt);

            if (vs_rise)      hl_cnt <= hs_rise ? CNT_ONE : '0;
            else if (hs_rise) hl_cnt <= sat_inc(hl_cnt);

            if (timeout) begin
                locked  <= 1'b0;
                prev_ok <= 1'b0;
            end else if (frame_end) begin
                v_active <= va_fin;
                v_total  <= vt_fin;
                prev_ha  <= ha_fin;
                prev_ht  <= ht_fin;
                prev_va  <= va_fin;
                prev_vt  <= vt_fin;
                prev_ok  <= 1'b1;
                locked   <= prev_ok && meas_same && !err_fin;
            end

            if (de_rise)        pix_x <= '0;
            else if (pix_valid) pix_x <= sat_inc(pix_x);

            if (frame_start)   pix_y <= '0;
            else if (line_end) pix_y <= sat_inc(pix_y);
        end
    end

endmodule
